// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared definitions for the RV32I 5-stage pipeline: datapath
//               width defaults, ALUControl encodings, the decoded control
//               bundle carried between stages and the all-zero bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int c_XLEN   = 32;
    localparam int c_REG_AW = 5;
    localparam int c_CNT_W  = 32;

    // ALUControl encodings produced by control_unit_top
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    // Decoded control bits travelling down the pipe with an instruction
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       result_src;
        logic       alu_src;
        logic       branch;
        logic [2:0] alu_ctrl;
    } ctrl_bundle_t;

    // A bubble carries no side effects: every control bit cleared
    localparam ctrl_bundle_t c_BUBBLE = '0;

    // Squash the control bits of an instruction that is not real
    function automatic ctrl_bundle_t gate_ctrl(input ctrl_bundle_t ctrl,
                                               input logic         valid);
        return valid ? ctrl : c_BUBBLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_use_detector.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detector
// Description : Combinational load-use hazard detection. Flags when the
//               instruction in Execute is a real load writing a non-x0
//               register that the real instruction in Decode reads.
// Ports       : valid_e/result_src_e/reg_write_e/rd_e - Execute-stage state
//               valid_d/rs1_d/rs2_d                   - Decode-stage sources
//               load_use                              - hazard present
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detector #(
    parameter int REG_AW = 5
) (
    input  logic              valid_e,
    input  logic              result_src_e,
    input  logic              reg_write_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    output logic              load_use
);

    logic w_is_load_e;
    logic w_src_match;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign w_is_load_e = valid_e & result_src_e & reg_write_e & (rd_e != '0);
    assign w_src_match = (rs1_d == rd_e) | (rs2_d == rd_e);
    assign load_use    = w_is_load_e & valid_d & w_src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_reg
// Description : ID/EX pipeline register. Registers Decode control and data
//               for Execute, inserts a one-cycle bubble (and stalls PC and
//               IF/ID) on a load-use hazard, honours branch flush from EX and
//               freezes completely under a data-memory stall.
//               Optional macro ID_EX_PERF_CNT_EN adds saturating bubble and
//               flush counters; without it the counter ports read zero.
// Ports       : clk, rst (async, active high)
//               *_d        - Decode-stage control / data inputs
//               flush_e    - branch taken in EX
//               mem_stall  - data memory not ready, hold everything
//               stall_f/d  - hold PC / IF-ID register
//               *_e        - registered Execute-stage outputs
//               bubble_cnt, flush_cnt - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN   = c_XLEN,
    parameter int REG_AW = c_REG_AW,
    parameter int CNT_W  = c_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic              result_src_d,
    input  logic              alu_src_d,
    input  logic              branch_d,
    input  logic [2:0]        alu_ctrl_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              flush_e,
    input  logic              mem_stall,
    output logic              stall_f,
    output logic              stall_d,
    output logic              valid_e,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              result_src_e,
    output logic              alu_src_e,
    output logic              branch_e,
    output logic [2:0]        alu_ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ctrl_bundle_t      w_ctrl_d;
    logic              w_load_use;
    logic              w_stall;

    logic              r_valid_e;
    ctrl_bundle_t      r_ctrl_e;
    logic [XLEN-1:0]   r_rd1_e;
    logic [XLEN-1:0]   r_rd2_e;
    logic [XLEN-1:0]   r_imm_ext_e;
    logic [XLEN-1:0]   r_pc_e;
    logic [XLEN-1:0]   r_pc_plus4_e;
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;
    logic [REG_AW-1:0] r_rd_e;

    assign w_ctrl_d = '{reg_write:  reg_write_d,
                        mem_write:  mem_write_d,
                        result_src: result_src_d,
                        alu_src:    alu_src_d,
                        branch:     branch_d,
                        alu_ctrl:   alu_ctrl_d};

    load_use_detector #(
        .REG_AW(REG_AW)
    ) u_load_use_detector (
        .valid_e      (r_valid_e),
        .result_src_e (r_ctrl_e.result_src),
        .reg_write_e  (r_ctrl_e.reg_write),
        .rd_e         (r_rd_e),
        .valid_d      (valid_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .load_use     (w_load_use)
    );

    // A flush already discards Decode and a memory stall freezes the whole
    // pipe, so in both cases the front end must not be held by the hazard.
    assign w_stall = w_load_use & ~flush_e & ~mem_stall;
    assign stall_f = w_stall;
    assign stall_d = w_stall;

    // Priority: memory stall (hold) > flush (bubble) > load-use (bubble) >
    // capture. Under a hold the flush is dropped; EX re-asserts it later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_e    <= 1'b0;
            r_ctrl_e     <= c_BUBBLE;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_ext_e  <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
        end else if (mem_stall) begin
            r_valid_e    <= r_valid_e;
        end else if (flush_e || w_load_use) begin
            r_valid_e    <= 1'b0;
            r_ctrl_e     <= c_BUBBLE;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_ext_e  <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
            r_rs1_e      <= '0;
            r_rs2_e      <= '0;
            r_rd_e       <= '0;
        end else begin
            r_valid_e    <= valid_d;
            r_ctrl_e     <= gate_ctrl(w_ctrl_d, valid_d);
            r_rd1_e      <= rd1_d;
            r_rd2_e      <= rd2_d;
            r_imm_ext_e  <= imm_ext_d;
            r_pc_e       <= pc_d;
            r_pc_plus4_e <= pc_plus4_d;
            r_rs1_e      <= rs1_d;
            r_rs2_e      <= rs2_d;
            r_rd_e       <= rd_d;
        end
    end

    assign valid_e      = r_valid_e;
    assign reg_write_e  = r_ctrl_e.reg_write;
    assign mem_write_e  = r_ctrl_e.mem_write;
    assign result_src_e = r_ctrl_e.result_src;
    assign alu_src_e    = r_ctrl_e.alu_src;
    assign branch_e     = r_ctrl_e.branch;
    assign alu_ctrl_e   = r_ctrl_e.alu_ctrl;
    assign rd1_e        = r_rd1_e;
    assign rd2_e        = r_rd2_e;
    assign imm_ext_e    = r_imm_ext_e;
    assign pc_e         = r_pc_e;
    assign pc_plus4_e   = r_pc_plus4_e;
    assign rs1_e        = r_rs1_e;
    assign rs2_e        = r_rs2_e;
    assign rd_e         = r_rd_e;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Counters follow the same priority as the E registers: nothing counts
    // while memory stalls, and a flush masks a coincident load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!mem_stall && flush_e && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_stall && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule
`default_nettype wire
